// File: rtl/instr_sequencer_pkg.sv
// Shared constants, instruction field offsets and sequencer state encoding
// for the instruction fetch/sequencing stage.
package instr_sequencer_pkg;

  localparam int IW          = 17;
  localparam int AW          = 4;

  localparam int WEN_BIT     = 0;
  localparam int ADDR1_LSB   = 1;
  localparam int ADDR2_LSB   = 5;
  localparam int ALUSEL_LSB  = 9;
  localparam int RAMADDR_LSB = 13;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STEP_WAIT,
    DONE
  } seq_state_t;

endpackage

// File: rtl/instr_sequencer_prog_mem.sv
// Program store: 2**AW words of IW bits, synchronous write, asynchronous read.
module instr_sequencer_prog_mem #(
  parameter int IW = 17,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [IW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [IW-1:0] rd_data
);

  logic [IW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: issues stored instruction words to the datapath one per
// accepted handshake, in free-run or single-step mode, with optional stop on zf.
module instr_sequencer #(
  parameter int IW = instr_sequencer_pkg::IW,
  parameter int AW = instr_sequencer_pkg::AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [IW-1:0] prog_data,
  input  logic [AW-1:0] prog_len,
  input  logic          start,
  input  logic          stop,
  input  logic          step_mode,
  input  logic          step,
  input  logic          stop_on_zf,
  input  logic          zf,
  input  logic          out_ready,
  output logic [IW-1:0] instr,
  output logic          instr_valid,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done
);

  import instr_sequencer_pkg::*;

  seq_state_t    state;
  logic [IW-1:0] instr_p1;
  logic          vld_p1;
  logic [AW-1:0] pc_p1;
  logic          busy_p1;
  logic          done_p1;
  logic [AW-1:0] cfg_len;
  logic          cfg_step;
  logic          cfg_zf;

  logic          idle_like;
  logic          mem_we;
  logic          start_ok;
  logic          xfer;
  logic          last_xfer;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] rd_addr;
  logic [IW-1:0] rd_data;

  assign idle_like = (state == IDLE) || (state == DONE);
  assign mem_we    = prog_we & idle_like;
  assign start_ok  = start & ~prog_we & idle_like;
  assign xfer      = vld_p1 & out_ready;
  assign last_xfer = (pc_p1 == cfg_len) | (cfg_zf & zf);
  assign pc_inc    = pc_p1 + AW'(1);

  // One read port serves all loads: word 0 on start, the successor while
  // running, and the already-advanced pc when a step releases it.
  always_comb begin
    rd_addr = pc_p1;
    if (idle_like)           rd_addr = '0;
    else if (state == RUN)   rd_addr = pc_inc;
  end

  instr_sequencer_prog_mem #(.IW(IW), .AW(AW)) u_prog_mem (
    .clk     (clk),
    .we      (mem_we),
    .wr_addr (prog_addr),
    .wr_data (prog_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      instr_p1 <= '0;
      vld_p1   <= 1'b0;
      pc_p1    <= '0;
      busy_p1  <= 1'b0;
      done_p1  <= 1'b0;
      cfg_len  <= '0;
      cfg_step <= 1'b0;
      cfg_zf   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            state    <= RUN;
            instr_p1 <= rd_data;
            vld_p1   <= 1'b1;
            pc_p1    <= '0;
            busy_p1  <= 1'b1;
            done_p1  <= 1'b0;
            cfg_len  <= prog_len;
            cfg_step <= step_mode;
            cfg_zf   <= stop_on_zf;
          end
        end
        RUN: begin
          if (stop) begin
            state   <= IDLE;
            vld_p1  <= 1'b0;
            busy_p1 <= 1'b0;
            done_p1 <= 1'b0;
          end else if (xfer) begin
            if (last_xfer) begin
              state   <= DONE;
              vld_p1  <= 1'b0;
              busy_p1 <= 1'b0;
              done_p1 <= 1'b1;
            end else if (cfg_step) begin
              state  <= STEP_WAIT;
              vld_p1 <= 1'b0;
              pc_p1  <= pc_inc;
            end else begin
              instr_p1 <= rd_data;
              pc_p1    <= pc_inc;
            end
          end
        end
        STEP_WAIT: begin
          if (stop) begin
            state   <= IDLE;
            busy_p1 <= 1'b0;
            done_p1 <= 1'b0;
          end else if (step) begin
            state    <= RUN;
            instr_p1 <= rd_data;
            vld_p1   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write-enable is masked so the RAM is never written without a valid word.
  assign instr       = {instr_p1[IW-1:1], instr_p1[WEN_BIT] & vld_p1};
  assign instr_valid = vld_p1;
  assign pc          = pc_p1;
  assign busy        = busy_p1;
  assign done        = done_p1;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [16:0] prog_data;
  logic [3:0]  prog_len;
  logic        start;
  logic        stop;
  logic        step_mode;
  logic        step;
  logic        stop_on_zf;
  logic        zf;
  logic        out_ready;
  logic [16:0] instr;
  logic        instr_valid;
  logic [3:0]  pc;
  logic        busy;
  logic        done;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instr_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_len    (prog_len),
    .start       (start),
    .stop        (stop),
    .step_mode   (step_mode),
    .step        (step),
    .stop_on_zf  (stop_on_zf),
    .zf          (zf),
    .out_ready   (out_ready),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .busy        (busy),
    .done        (done)
  );

  typedef struct packed {
    logic        rst_n;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [16:0] prog_data;
    logic [3:0]  prog_len;
    logic        start;
    logic        stop;
    logic        step_mode;
    logic        step;
    logic        stop_on_zf;
    logic        zf;
    logic        out_ready;
    logic        e_vld;
    logic [3:0]  e_pc;
    logic [16:0] e_instr;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t tbl [13];

  // Behavioural model state for the randomized phase
  logic [16:0] mm [16];
  logic        m_run, m_vld, m_done, m_sm, m_zfl;
  logic [3:0]  m_pc, m_len;
  logic [16:0] m_word;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic ev, input logic [3:0] ep,
                         input logic [16:0] ei, input logic eb, input logic ed);
    chk({nm, ".valid"}, 32'(instr_valid), 32'(ev));
    chk({nm, ".pc"},    32'(pc),          32'(ep));
    chk({nm, ".instr"}, 32'(instr),       32'(ei));
    chk({nm, ".busy"},  32'(busy),        32'(eb));
    chk({nm, ".done"},  32'(done),        32'(ed));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulses_low;
    prog_we = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    step    = 1'b0;
    zf      = 1'b0;
  endtask

  function automatic logic [16:0] wgen(input int i);
    logic [31:0] t;
    t = (32'(i) * 32'h2F1D + 32'h0B35) ^ (32'(i) << 3);
    return t[16:0];
  endfunction

  initial begin
    rst_n = 1'b0; prog_addr = '0; prog_data = '0; prog_len = '0;
    step_mode = 1'b0; stop_on_zf = 1'b0; out_ready = 1'b0;
    pulses_low();

    // rst_n we addr data len start stop sm step szf zf rdy | vld pc instr busy done
    tbl[0]  = '{1'b0,1'b0,4'd0,17'h00000,4'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,4'd0,17'h00000,1'b0,1'b0};
    tbl[1]  = '{1'b1,1'b1,4'd0,17'h04A23,4'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,4'd0,17'h00000,1'b0,1'b0};
    tbl[2]  = '{1'b1,1'b1,4'd1,17'h00C45,4'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,4'd0,17'h00000,1'b0,1'b0};
    tbl[3]  = '{1'b1,1'b1,4'd2,17'h08206,4'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,4'd0,17'h00000,1'b0,1'b0};
    tbl[4]  = '{1'b1,1'b0,4'd0,17'h00000,4'd2,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,4'd0,17'h04A23,1'b1,1'b0};
    tbl[5]  = '{1'b1,1'b0,4'd0,17'h00000,4'd2,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,4'd1,17'h00C45,1'b1,1'b0};
    tbl[6]  = '{1'b1,1'b0,4'd0,17'h00000,4'd2,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,4'd2,17'h08206,1'b1,1'b0};
    tbl[7]  = '{1'b1,1'b0,4'd0,17'h00000,4'd2,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,4'd2,17'h08206,1'b0,1'b1};
    tbl[8]  = '{1'b1,1'b0,4'd0,17'h00000,4'd2,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,4'd0,17'h04A23,1'b1,1'b0};
    tbl[9]  = '{1'b1,1'b0,4'd0,17'h00000,4'd2,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,4'd0,17'h04A23,1'b1,1'b0};
    tbl[10] = '{1'b1,1'b0,4'd0,17'h00000,4'd2,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,4'd0,17'h04A23,1'b1,1'b0};
    tbl[11] = '{1'b1,1'b0,4'd0,17'h00000,4'd2,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,4'd0,17'h04A23,1'b1,1'b0};
    tbl[12] = '{1'b1,1'b0,4'd0,17'h00000,4'd2,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,4'd0,17'h04A22,1'b0,1'b0};

    #2;
    for (int i = 0; i < 13; i++) begin
      rst_n = tbl[i].rst_n;  prog_we = tbl[i].prog_we;  prog_addr = tbl[i].prog_addr;
      prog_data = tbl[i].prog_data;  prog_len = tbl[i].prog_len;  start = tbl[i].start;
      stop = tbl[i].stop;  step_mode = tbl[i].step_mode;  step = tbl[i].step;
      stop_on_zf = tbl[i].stop_on_zf;  zf = tbl[i].zf;  out_ready = tbl[i].out_ready;
      tick();
      chk_out($sformatf("tbl%0d", i), tbl[i].e_vld, tbl[i].e_pc, tbl[i].e_instr,
              tbl[i].e_busy, tbl[i].e_done);
    end
    pulses_low();

    // Single-step run
    step_mode = 1'b1; prog_len = 4'd2; out_ready = 1'b1; start = 1'b1;
    tick(); chk_out("step.s0", 1'b1, 4'd0, 17'h04A23, 1'b1, 1'b0);
    start = 1'b0;
    tick(); chk_out("step.w1", 1'b0, 4'd1, 17'h04A22, 1'b1, 1'b0);
    tick(); chk_out("step.w1b", 1'b0, 4'd1, 17'h04A22, 1'b1, 1'b0);
    step = 1'b1;
    tick(); chk_out("step.s1", 1'b1, 4'd1, 17'h00C45, 1'b1, 1'b0);
    step = 1'b0;
    tick(); chk_out("step.w2", 1'b0, 4'd2, 17'h00C44, 1'b1, 1'b0);
    step = 1'b1;
    tick(); chk_out("step.s2", 1'b1, 4'd2, 17'h08206, 1'b1, 1'b0);
    step = 1'b0;
    tick(); chk_out("step.end", 1'b0, 4'd2, 17'h08206, 1'b0, 1'b1);
    step_mode = 1'b0;

    // Early stop on zero flag at pc=1
    stop_on_zf = 1'b1; start = 1'b1;
    tick(); chk_out("zf.s0", 1'b1, 4'd0, 17'h04A23, 1'b1, 1'b0);
    start = 1'b0;
    tick(); chk_out("zf.s1", 1'b1, 4'd1, 17'h00C45, 1'b1, 1'b0);
    zf = 1'b1;
    tick(); chk_out("zf.end", 1'b0, 4'd1, 17'h00C44, 1'b0, 1'b1);
    zf = 1'b0;
    tick(); chk_out("zf.hold", 1'b0, 4'd1, 17'h00C44, 1'b0, 1'b1);
    stop_on_zf = 1'b0;

    // stop colliding with a transfer, writes and starts in various states
    start = 1'b1;
    tick(); chk_out("stp.s0", 1'b1, 4'd0, 17'h04A23, 1'b1, 1'b0);
    start = 1'b0;
    tick(); chk_out("stp.s1", 1'b1, 4'd1, 17'h00C45, 1'b1, 1'b0);
    stop = 1'b1;
    tick(); chk_out("stp.abort", 1'b0, 4'd1, 17'h00C44, 1'b0, 1'b0);
    stop = 1'b0; prog_we = 1'b1; prog_addr = 4'd3; prog_data = 17'h1ABCD; start = 1'b1;
    tick(); chk_out("stp.we_start", 1'b0, 4'd1, 17'h00C44, 1'b0, 1'b0);
    prog_we = 1'b0; prog_len = 4'd3;
    tick(); chk_out("stp.r0", 1'b1, 4'd0, 17'h04A23, 1'b1, 1'b0);
    start = 1'b0;
    tick(); chk_out("stp.r1", 1'b1, 4'd1, 17'h00C45, 1'b1, 1'b0);
    out_ready = 1'b0; start = 1'b1; prog_we = 1'b1; prog_addr = 4'd2; prog_data = 17'h1FFFF;
    tick(); chk_out("stp.busy_ign", 1'b1, 4'd1, 17'h00C45, 1'b1, 1'b0);
    start = 1'b0; prog_we = 1'b0; out_ready = 1'b1;
    tick(); chk_out("stp.r2", 1'b1, 4'd2, 17'h08206, 1'b1, 1'b0);
    tick(); chk_out("stp.r3", 1'b1, 4'd3, 17'h1ABCD, 1'b1, 1'b0);
    tick(); chk_out("stp.end", 1'b0, 4'd3, 17'h1ABCC, 1'b0, 1'b1);
    stop = 1'b1;
    tick(); chk_out("stp.done_ign", 1'b0, 4'd3, 17'h1ABCC, 1'b0, 1'b1);
    stop = 1'b0;

    // Full-depth program, then reset mid-run
    for (int i = 0; i < 16; i++) begin
      prog_we = 1'b1; prog_addr = 4'(i); prog_data = wgen(i);
      tick();
    end
    prog_we = 1'b0; prog_len = 4'd15; start = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick(); chk_out($sformatf("full.pc%0d", i), 1'b1, 4'(i), wgen(i), 1'b1, 1'b0);
      start = 1'b0;
    end
    tick(); chk_out("full.end", 1'b0, 4'd15, {wgen(15) >> 1, 1'b0}, 1'b0, 1'b1);
    start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); chk_out("rst.pre", 1'b1, 4'd2, wgen(2), 1'b1, 1'b0);
    rst_n = 1'b0;
    tick(); chk_out("rst.mid", 1'b0, 4'd0, 17'h00000, 1'b0, 1'b0);
    rst_n = 1'b1; out_ready = 1'b0; start = 1'b1;
    tick(); chk_out("rst.mem0", 1'b1, 4'd0, wgen(0), 1'b1, 1'b0);
    start = 1'b0; out_ready = 1'b1;
    tick(); chk_out("rst.mem1", 1'b1, 4'd1, wgen(1), 1'b1, 1'b0);
    stop = 1'b1;
    tick(); stop = 1'b0;

    // Randomized phase against the behavioural model
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      prog_we = 1'b1; prog_addr = 4'(i); prog_data = 17'($urandom);
      mm[i] = prog_data;
      tick();
    end
    prog_we = 1'b0;
    m_run = 0; m_vld = 0; m_done = 0; m_sm = 0; m_zfl = 0;
    m_pc = '0; m_len = '0; m_word = '0;

    for (int c = 0; c < 3000; c++) begin
      chk_out("rand", m_vld, m_pc, {m_word[16:1], m_word[0] & m_vld}, m_run, m_done);
      rst_n      = ($urandom_range(0, 299) != 0);
      prog_we    = ($urandom_range(0, 5) == 0);
      prog_addr  = 4'($urandom);
      prog_data  = 17'($urandom);
      prog_len   = 4'($urandom);
      start      = ($urandom_range(0, 4) == 0);
      stop       = ($urandom_range(0, 39) == 0);
      step_mode  = 1'($urandom);
      step       = ($urandom_range(0, 2) == 0);
      stop_on_zf = 1'($urandom);
      zf         = ($urandom_range(0, 7) == 0);
      out_ready  = ($urandom_range(0, 3) != 0);

      if (!rst_n) begin
        m_run = 0; m_vld = 0; m_done = 0; m_sm = 0; m_zfl = 0;
        m_pc = '0; m_len = '0; m_word = '0;
      end else if (!m_run) begin
        if (prog_we) mm[prog_addr] = prog_data;
        else if (start) begin
          m_run = 1; m_vld = 1; m_done = 0; m_pc = '0; m_word = mm[0];
          m_len = prog_len; m_sm = step_mode; m_zfl = stop_on_zf;
        end
      end else if (stop) begin
        m_run = 0; m_vld = 0; m_done = 0;
      end else if (m_vld && out_ready) begin
        if (m_pc == m_len || (m_zfl && zf)) begin
          m_run = 0; m_vld = 0; m_done = 1;
        end else if (m_sm) begin
          m_vld = 0; m_pc = m_pc + 4'd1;
        end else begin
          m_pc = m_pc + 4'd1; m_word = mm[m_pc];
        end
      end else if (!m_vld && step) begin
        m_vld = 1; m_word = mm[m_pc];
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
